id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the MIPS datapath, placed directly downstream of the opcode control decoder. Each cycle it captures the decoded control bundle (RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, Jal, ALUOp), the register-file operands, the immediate and the register addresses. It presents them to the execute stage one cycle later. It also detects load-use hazards, inserts bubbles, and flushes on redirect requests from the branch/jump resolution logic.

## Interface
- DATA_WIDTH, 32, width of PC+4, operand and immediate fields
- REG_ADDR_WIDTH, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- RegDst_ID, BranchEQ_ID, BranchNE_ID, MemRead_ID, MemtoReg_ID, MemWrite_ID, ALUSrc_ID, RegWrite_ID, Jump_ID, Jal_ID  in  1 each  decoder outputs
- ALUOp_ID  in  4  decoder ALU operation
- Valid_ID  in  1  ID slot holds a real instruction
- PC4_ID, ReadData1_ID, ReadData2_ID, Immediate_ID  in  DATA_WIDTH  ID-stage data
- Rs_ID, Rt_ID, Rd_ID  in  REG_ADDR_WIDTH  ID-stage register fields
- Flush  in  1  taken branch/jump; discard the ID instruction
- Same names with _EX suffix  out  same widths  registered copies
- Valid_EX  out  1  EX slot holds a real instruction
- Stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- Three capture modes per edge, in priority order: Flush > load-use bubble > normal.
- Normal: all _EX outputs load their _ID inputs. Valid_EX loads Valid_ID.
- Bubble (Flush=1, or Stall=1):
  - All eleven control outputs load 0. ALUOp_EX loads 4'b0000.
  - Valid_EX loads 0.
  - Data and register-field outputs still load their _ID inputs; they are don't-care downstream.
- Load-use hazard term: MemRead_EX & Valid_EX & Valid_ID & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID)). The comparison is conservative and ignores ALUSrc.
- Stall = hazard & ~Flush. A simultaneous Flush discards the ID instruction, so no hold is requested.
- A bubble clears MemRead_EX. Every load-use stall therefore lasts exactly one cycle.
- A bubble never writes registers or memory downstream, because RegWrite_EX, MemWrite_EX and MemRead_EX are all 0.

## Timing
- Latency: exactly 1 cycle, ID input to _EX output.
- Stall is combinational from the current _EX registers and the ID inputs. It is valid in the same cycle, before the edge.
- Reset asserted (low): every output goes to 0 immediately, asynchronously, and stays 0 while reset is held. With MemRead_EX=0, Stall=0.
- Reset release: the first rising edge captures in normal mode.
- Reset mid-stall: the stall is cancelled immediately. Upstream stages reset together with this block.
- Back-to-back loads: each dependent consumer incurs its own single bubble. There is no cumulative stall.

## Configuration
- ID_EX_HAZARD_EN defined: the load-use detector is compiled in as described.
- ID_EX_HAZARD_EN undefined: the hazard term is constant 0, so Stall is tied 0 and bubbles come only from Flush. Software scheduling must then insert NOPs.

## Structure
- mips_pkg contains:
  - opcode constants (R_TYPE=6'h00, ADDI=6'h08, ANDI=6'h0c, ORI=6'h0d, LUI=6'h0f, LW=6'h23, SW=6'h2b, BEQ=6'h04, BNE=6'h05, J=6'h02, JAL=6'h03)
  - ALUOp encodings
  - the 14-bit control-bundle width and bit indices (ALUOp[3:0], BranchEQ 4, BranchNE 5, MemWrite 6, MemRead 7, RegWrite 8, MemtoReg 9, ALUSrc 10, RegDst 11, Jump 12, Jal 13)
- Internally the controls are stored as one 14-bit register using the package indices.
- Sub-module hazard_detect: purely combinational load-use comparator producing the hazard term. It is instantiated only under ID_EX_HAZARD_EN.

## Test plan
- Reset: hold reset low with random inputs, then release.
  - Required: all _EX outputs, Valid_EX and Stall read 0 throughout.
  - Required: the first edge after release captures ADDI controls (ALUSrc=1, RegWrite=1, ALUOp=4'b1000).
- Pass-through: drive LW `lw $8,0($9)`, then `add $10,$11,$12`.
  - Required: the _EX outputs match each instruction's inputs one cycle later.
  - Required: Stall stays 0.
- Load-use: `lw $8,0($9)` in EX, `add $10,$8,$3` in ID.
  - Required: Stall=1 for one cycle.
  - Required: the next EX holds a bubble (Valid_EX=0, RegWrite_EX=0).
  - Required: the add reaches EX on the following cycle with Stall=0.
- Register zero: LW with Rt=$0 in EX and consumer Rs=$0.
  - Required: Stall=0.
- Flush with hazard: load-use condition present and Flush=1 in the same cycle.
  - Required: Stall=0.
  - Required: the next EX has Valid_EX=0 and all controls 0.
- Macro off: rebuild without ID_EX_HAZARD_EN and repeat the load-use scenario.
  - Required: Stall=0 and the add enters EX immediately with Valid_EX=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcodes, ALUOp encodings and control-bundle layout.
package mips_pkg;

  localparam int unsigned OPCODE_WIDTH = 6;
  localparam int unsigned ALUOP_WIDTH  = 4;
  localparam int unsigned CTRL_WIDTH   = 14;

  // Opcode constants
  localparam logic [OPCODE_WIDTH-1:0] R_TYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] ADDI   = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] ANDI   = 6'h0c;
  localparam logic [OPCODE_WIDTH-1:0] ORI    = 6'h0d;
  localparam logic [OPCODE_WIDTH-1:0] LUI    = 6'h0f;
  localparam logic [OPCODE_WIDTH-1:0] LW     = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] SW     = 6'h2b;
  localparam logic [OPCODE_WIDTH-1:0] BEQ    = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] BNE    = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] J      = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] JAL    = 6'h03;

  // ALUOp encodings; 0000 (address add) doubles as the bubble value
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_MEM    = 4'b0000;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_BRANCH = 4'b0001;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_RTYPE  = 4'b0010;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADDI   = 4'b1000;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ANDI   = 4'b1001;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ORI    = 4'b1010;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_LUI    = 4'b1011;

  // Control-bundle bit positions
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_ALUOP_MSB = 3;
  localparam int unsigned CTRL_BRANCHEQ  = 4;
  localparam int unsigned CTRL_BRANCHNE  = 5;
  localparam int unsigned CTRL_MEMWRITE  = 6;
  localparam int unsigned CTRL_MEMREAD   = 7;
  localparam int unsigned CTRL_REGWRITE  = 8;
  localparam int unsigned CTRL_MEMTOREG  = 9;
  localparam int unsigned CTRL_ALUSRC    = 10;
  localparam int unsigned CTRL_REGDST    = 11;
  localparam int unsigned CTRL_JUMP      = 12;
  localparam int unsigned CTRL_JAL       = 13;

  typedef logic [CTRL_WIDTH-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side inputs, EX-side registered copies, Flush and Stall.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      RegDst_ID, BranchEQ_ID, BranchNE_ID, MemRead_ID, MemtoReg_ID;
  logic                      MemWrite_ID, ALUSrc_ID, RegWrite_ID, Jump_ID, Jal_ID;
  logic [3:0]                ALUOp_ID;
  logic                      Valid_ID;
  logic [DATA_WIDTH-1:0]     PC4_ID, ReadData1_ID, ReadData2_ID, Immediate_ID;
  logic [REG_ADDR_WIDTH-1:0] Rs_ID, Rt_ID, Rd_ID;
  logic                      Flush;

  logic                      RegDst_EX, BranchEQ_EX, BranchNE_EX, MemRead_EX, MemtoReg_EX;
  logic                      MemWrite_EX, ALUSrc_EX, RegWrite_EX, Jump_EX, Jal_EX;
  logic [3:0]                ALUOp_EX;
  logic                      Valid_EX;
  logic [DATA_WIDTH-1:0]     PC4_EX, ReadData1_EX, ReadData2_EX, Immediate_EX;
  logic [REG_ADDR_WIDTH-1:0] Rs_EX, Rt_EX, Rd_EX;
  logic                      Stall;

  modport master (
    output RegDst_ID, BranchEQ_ID, BranchNE_ID, MemRead_ID, MemtoReg_ID,
           MemWrite_ID, ALUSrc_ID, RegWrite_ID, Jump_ID, Jal_ID, ALUOp_ID, Valid_ID,
           PC4_ID, ReadData1_ID, ReadData2_ID, Immediate_ID, Rs_ID, Rt_ID, Rd_ID, Flush,
    input  RegDst_EX, BranchEQ_EX, BranchNE_EX, MemRead_EX, MemtoReg_EX,
           MemWrite_EX, ALUSrc_EX, RegWrite_EX, Jump_EX, Jal_EX, ALUOp_EX, Valid_EX,
           PC4_EX, ReadData1_EX, ReadData2_EX, Immediate_EX, Rs_EX, Rt_EX, Rd_EX, Stall
  );

  modport slave (
    input  RegDst_ID, BranchEQ_ID, BranchNE_ID, MemRead_ID, MemtoReg_ID,
           MemWrite_ID, ALUSrc_ID, RegWrite_ID, Jump_ID, Jal_ID, ALUOp_ID, Valid_ID,
           PC4_ID, ReadData1_ID, ReadData2_ID, Immediate_ID, Rs_ID, Rt_ID, Rd_ID, Flush,
    output RegDst_EX, BranchEQ_EX, BranchNE_EX, MemRead_EX, MemtoReg_EX,
           MemWrite_EX, ALUSrc_EX, RegWrite_EX, Jump_EX, Jal_EX, ALUOp_EX, Valid_EX,
           PC4_EX, ReadData1_EX, ReadData2_EX, Immediate_EX, Rs_EX, Rt_EX, Rd_EX, Stall
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: a valid load in EX whose target (non-$0) feeds the ID instruction.
// Conservative: Rt_ID is compared even when the consumer uses an immediate.
module hazard_detect #(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      MemRead_EX,
  input  logic                      Valid_EX,
  input  logic                      Valid_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_EX,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_ID,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_ID,
  output logic                      hazard
);

  // Hazard term
  assign hazard = MemRead_EX & Valid_EX & Valid_ID
                & (Rt_EX != REG_ADDR_WIDTH'(0))
                & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and redirect flush.
// Optional feature macro: ID_EX_HAZARD_EN compiles in the load-use detector;
// without it Stall is tied low and only Flush creates bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  ctrl_t                     ctrlId, ctrlEx;
  logic                      validEx;
  logic [DATA_WIDTH-1:0]     pc4Ex, readData1Ex, readData2Ex, immediateEx;
  logic [REG_ADDR_WIDTH-1:0] rsEx, rtEx, rdEx;
  logic                      hazard, bubble;

`ifdef ID_EX_HAZARD_EN
  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uHazard (
    .MemRead_EX (ctrlEx[CTRL_MEMREAD]),
    .Valid_EX   (validEx),
    .Valid_ID   (bus.Valid_ID),
    .Rt_EX      (rtEx),
    .Rs_ID      (bus.Rs_ID),
    .Rt_ID      (bus.Rt_ID),
    .hazard     (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  // A flush discards the ID instruction, so holding upstream is pointless
  assign bus.Stall = hazard & ~bus.Flush;
  assign bubble    = bus.Flush | hazard;

  // Pack decoder outputs into the stored control bundle
  always_comb begin
    ctrlId                                = '0;
    ctrlId[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = bus.ALUOp_ID;
    ctrlId[CTRL_BRANCHEQ]                 = bus.BranchEQ_ID;
    ctrlId[CTRL_BRANCHNE]                 = bus.BranchNE_ID;
    ctrlId[CTRL_MEMWRITE]                 = bus.MemWrite_ID;
    ctrlId[CTRL_MEMREAD]                  = bus.MemRead_ID;
    ctrlId[CTRL_REGWRITE]                 = bus.RegWrite_ID;
    ctrlId[CTRL_MEMTOREG]                 = bus.MemtoReg_ID;
    ctrlId[CTRL_ALUSRC]                   = bus.ALUSrc_ID;
    ctrlId[CTRL_REGDST]                   = bus.RegDst_ID;
    ctrlId[CTRL_JUMP]                     = bus.Jump_ID;
    ctrlId[CTRL_JAL]                      = bus.Jal_ID;
  end

  // Pipeline register: controls/valid zeroed on bubble, data always captured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlEx      <= '0;
      validEx     <= 1'b0;
      pc4Ex       <= '0;
      readData1Ex <= '0;
      readData2Ex <= '0;
      immediateEx <= '0;
      rsEx        <= '0;
      rtEx        <= '0;
      rdEx        <= '0;
    end else begin
      ctrlEx      <= bubble ? '0 : ctrlId;
      validEx     <= bubble ? 1'b0 : bus.Valid_ID;
      pc4Ex       <= bus.PC4_ID;
      readData1Ex <= bus.ReadData1_ID;
      readData2Ex <= bus.ReadData2_ID;
      immediateEx <= bus.Immediate_ID;
      rsEx        <= bus.Rs_ID;
      rtEx        <= bus.Rt_ID;
      rdEx        <= bus.Rd_ID;
    end
  end

  // Unpack registered bundle to EX outputs
  assign bus.ALUOp_EX     = ctrlEx[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB];
  assign bus.BranchEQ_EX  = ctrlEx[CTRL_BRANCHEQ];
  assign bus.BranchNE_EX  = ctrlEx[CTRL_BRANCHNE];
  assign bus.MemWrite_EX  = ctrlEx[CTRL_MEMWRITE];
  assign bus.MemRead_EX   = ctrlEx[CTRL_MEMREAD];
  assign bus.RegWrite_EX  = ctrlEx[CTRL_REGWRITE];
  assign bus.MemtoReg_EX  = ctrlEx[CTRL_MEMTOREG];
  assign bus.ALUSrc_EX    = ctrlEx[CTRL_ALUSRC];
  assign bus.RegDst_EX    = ctrlEx[CTRL_REGDST];
  assign bus.Jump_EX      = ctrlEx[CTRL_JUMP];
  assign bus.Jal_EX       = ctrlEx[CTRL_JAL];
  assign bus.Valid_EX     = validEx;
  assign bus.PC4_EX       = pc4Ex;
  assign bus.ReadData1_EX = readData1Ex;
  assign bus.ReadData2_EX = readData2Ex;
  assign bus.Immediate_EX = immediateEx;
  assign bus.Rs_EX        = rsEx;
  assign bus.Rt_EX        = rtEx;
  assign bus.Rd_EX        = rdEx;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus load-use / flush / reset sequences.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Hand-encoded control bundles (bit layout from mips_pkg)
  localparam logic [13:0] C_NONE = 14'h0000;
  localparam logic [13:0] C_LW   = 14'h0780; // ALUSrc MemtoReg RegWrite MemRead, ALUOp 0000
  localparam logic [13:0] C_ADD  = 14'h0902; // RegDst RegWrite, ALUOp 0010
  localparam logic [13:0] C_ADDI = 14'h0508; // ALUSrc RegWrite, ALUOp 1000
  localparam logic [13:0] C_SW   = 14'h0440; // ALUSrc MemWrite
  localparam logic [13:0] C_BEQ  = 14'h0011; // BranchEQ, ALUOp 0001
  localparam logic [13:0] C_JAL  = 14'h3100; // Jal Jump RegWrite

  typedef struct {
    logic [13:0] ctrl;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        flush;
    logic        expStall;
    logic [13:0] expCtrl;
    logic        expValid;
  } vec_t;

  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;
  logic [127:0] expData;
  logic [14:0]  expRegs;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] getCtrl();
    logic [13:0] c;
    c = '0;
    c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = bus.ALUOp_EX;
    c[CTRL_BRANCHEQ] = bus.BranchEQ_EX;
    c[CTRL_BRANCHNE] = bus.BranchNE_EX;
    c[CTRL_MEMWRITE] = bus.MemWrite_EX;
    c[CTRL_MEMREAD]  = bus.MemRead_EX;
    c[CTRL_REGWRITE] = bus.RegWrite_EX;
    c[CTRL_MEMTOREG] = bus.MemtoReg_EX;
    c[CTRL_ALUSRC]   = bus.ALUSrc_EX;
    c[CTRL_REGDST]   = bus.RegDst_EX;
    c[CTRL_JUMP]     = bus.Jump_EX;
    c[CTRL_JAL]      = bus.Jal_EX;
    return c;
  endfunction

  task automatic drive(input logic [13:0] c, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    bus.ALUOp_ID     = c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB];
    bus.BranchEQ_ID  = c[CTRL_BRANCHEQ];
    bus.BranchNE_ID  = c[CTRL_BRANCHNE];
    bus.MemWrite_ID  = c[CTRL_MEMWRITE];
    bus.MemRead_ID   = c[CTRL_MEMREAD];
    bus.RegWrite_ID  = c[CTRL_REGWRITE];
    bus.MemtoReg_ID  = c[CTRL_MEMTOREG];
    bus.ALUSrc_ID    = c[CTRL_ALUSRC];
    bus.RegDst_ID    = c[CTRL_REGDST];
    bus.Jump_ID      = c[CTRL_JUMP];
    bus.Jal_ID       = c[CTRL_JAL];
    bus.Valid_ID     = v;
    bus.Rs_ID        = rs;
    bus.Rt_ID        = rt;
    bus.Rd_ID        = rd;
    bus.Flush        = fl;
    bus.PC4_ID       = $urandom;
    bus.ReadData1_ID = $urandom;
    bus.ReadData2_ID = $urandom;
    bus.Immediate_ID = $urandom;
    expData = {bus.PC4_ID, bus.ReadData1_ID, bus.ReadData2_ID, bus.Immediate_ID};
    expRegs = {rs, rt, rd};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEx(input string nm, input logic [13:0] c, input logic v);
    chk({nm, ".ctrl"}, 128'(getCtrl()), 128'(c));
    chk({nm, ".valid"}, 128'(bus.Valid_EX), 128'(v));
    chk({nm, ".data"}, {bus.PC4_EX, bus.ReadData1_EX, bus.ReadData2_EX, bus.Immediate_EX}, expData);
    chk({nm, ".regs"}, 128'({bus.Rs_EX, bus.Rt_EX, bus.Rd_EX}), 128'(expRegs));
  endtask

  task automatic checkZero(input string nm);
    chk({nm, ".ctrl"}, 128'(getCtrl()), 128'(0));
    chk({nm, ".valid"}, 128'(bus.Valid_EX), 128'(0));
    chk({nm, ".stall"}, 128'(bus.Stall), 128'(0));
    chk({nm, ".data"}, {bus.PC4_EX, bus.ReadData1_EX, bus.ReadData2_EX, bus.Immediate_EX}, 128'(0));
    chk({nm, ".regs"}, 128'({bus.Rs_EX, bus.Rt_EX, bus.Rd_EX}), 128'(0));
  endtask

  initial begin
    // Stateful vector sequence, none of which trips the load-use detector
    tbl[0]  = '{C_ADDI, 1'b1, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, C_ADDI, 1'b1}; // first edge after reset
    tbl[1]  = '{C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b0, C_LW,   1'b1}; // lw $8,0($9)
    tbl[2]  = '{C_ADD,  1'b1, 5'd11, 5'd12, 5'd10, 1'b0, 1'b0, C_ADD,  1'b1}; // add $10,$11,$12
    tbl[3]  = '{C_LW,   1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 1'b0, C_LW,   1'b1}; // lw $0,0($9)
    tbl[4]  = '{C_ADD,  1'b1, 5'd0,  5'd5,  5'd6,  1'b0, 1'b0, C_ADD,  1'b1}; // uses $0: no stall
    tbl[5]  = '{C_SW,   1'b1, 5'd3,  5'd4,  5'd0,  1'b1, 1'b0, C_NONE, 1'b0}; // flushed store
    tbl[6]  = '{C_BEQ,  1'b0, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, C_BEQ,  1'b0}; // invalid slot
    tbl[7]  = '{C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b0, C_LW,   1'b1};
    tbl[8]  = '{C_ADD,  1'b0, 5'd8,  5'd3,  5'd10, 1'b0, 1'b0, C_ADD,  1'b0}; // invalid consumer
    tbl[9]  = '{C_JAL,  1'b1, 5'd0,  5'd0,  5'd31, 1'b0, 1'b0, C_JAL,  1'b1};
    tbl[10] = '{C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b1, 1'b0, C_NONE, 1'b0}; // flushed load
    tbl[11] = '{C_ADD,  1'b1, 5'd8,  5'd3,  5'd10, 1'b0, 1'b0, C_ADD,  1'b1}; // no load in EX

    // Reset held with random inputs
    reset = 1'b0;
    drive(14'($urandom), 1'b1, 5'd8, 5'd8, 5'd8, 1'b0);
    #1;
    checkZero("rst0");
    for (int i = 0; i < 3; i++) begin
      drive(14'($urandom) | C_LW, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      tick();
      checkZero("rst_hold");
    end
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ctrl, tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].flush);
      #1;
      chk($sformatf("vec%0d.stall", i), 128'(bus.Stall), 128'(tbl[i].expStall));
      tick();
      checkEx($sformatf("vec%0d", i), tbl[i].expCtrl, tbl[i].expValid);
    end

    // Load-use: lw $8,0($9) then add $10,$8,$3
    drive(C_LW, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
    tick();
    checkEx("lu.lw", C_LW, 1'b1);
    drive(C_ADD, 1'b1, 5'd8, 5'd3, 5'd10, 1'b0);
    #1;
`ifdef ID_EX_HAZARD_EN
    chk("lu.stall", 128'(bus.Stall), 128'(1));
    tick();
    checkEx("lu.bubble", C_NONE, 1'b0);
    chk("lu.bubble_regwrite", 128'(bus.RegWrite_EX), 128'(0));
    chk("lu.stall_after", 128'(bus.Stall), 128'(0));
    tick();
    checkEx("lu.add", C_ADD, 1'b1);
`else
    chk("lu.stall_off", 128'(bus.Stall), 128'(0));
    tick();
    checkEx("lu.add_off", C_ADD, 1'b1);
`endif

    // Flush coincident with a load-use condition
    drive(C_LW, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 1'b1, 5'd8, 5'd3, 5'd10, 1'b1);
    #1;
    chk("fl.stall", 128'(bus.Stall), 128'(0));
    tick();
    checkEx("fl.ex", C_NONE, 1'b0);

    // Back-to-back loads: dependent load (Rs match), then consumer (Rt match)
    drive(C_LW, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_LW, 1'b1, 5'd8, 5'd9, 5'd0, 1'b0);
    #1;
`ifdef ID_EX_HAZARD_EN
    chk("bb.stall1", 128'(bus.Stall), 128'(1));
    tick();
    checkEx("bb.bubble1", C_NONE, 1'b0);
    chk("bb.stall1_end", 128'(bus.Stall), 128'(0));
`else
    chk("bb.stall1_off", 128'(bus.Stall), 128'(0));
`endif
    tick();
    checkEx("bb.lw2", C_LW, 1'b1);
    drive(C_ADD, 1'b1, 5'd1, 5'd9, 5'd4, 1'b0);
    #1;
`ifdef ID_EX_HAZARD_EN
    chk("bb.stall2", 128'(bus.Stall), 128'(1));
    tick();
    checkEx("bb.bubble2", C_NONE, 1'b0);
    chk("bb.stall2_end", 128'(bus.Stall), 128'(0));
`else
    chk("bb.stall2_off", 128'(bus.Stall), 128'(0));
`endif
    tick();
    checkEx("bb.add", C_ADD, 1'b1);

    // Reset asserted while a stall is pending
    drive(C_LW, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 1'b1, 5'd8, 5'd3, 5'd10, 1'b0);
    #1;
`ifdef ID_EX_HAZARD_EN
    chk("mr.stall_pre", 128'(bus.Stall), 128'(1));
`endif
    reset = 1'b0;
    #1;
    checkZero("mr.async");
    tick();
    checkZero("mr.hold");
    reset = 1'b1;
    drive(C_ADDI, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    checkEx("mr.release", C_ADDI, 1'b1);
    chk("mr.alusrc", 128'(bus.ALUSrc_EX), 128'(1));
    chk("mr.aluop", 128'(bus.ALUOp_EX), 128'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
